// File: rtl/joy_serial_scanner.sv
// -----------------------------------------------------------------------------
// joy_serial_scanner
//
// Drives the external joystick shift register that carries both arcade player
// inputs. It generates the serial clock (joy_clk) and the active-low parallel
// load strobe (joy_load) from the core clock. It shifts one 24-bit frame in
// from joy_data and commits it to two 12-bit active-low joystick words in a
// single clock cycle, so a partially shifted frame is never visible.
//
// Parameters
//   CLK_DIV      clk cycles per joy_clk half-period (minimum 4)
//   GAP_PERIODS  idle joy_clk periods after each frame before the next load
//   FILTER       1 = commit a frame only when it matches the previous raw frame
//
// Ports
//   clk         in   core clock
//   reset_n     in   asynchronous active-low reset
//   enable      in   1 = scan continuously, 0 = stop once the current frame ends
//   joy_clk     out  serial clock to the shift register
//   joy_load    out  active-low parallel load to the shift register
//   joy_data    in   serial data from the shift register (asynchronous)
//   joy1        out  player 1 word, active-low
//   joy2        out  player 2 word, active-low
//   frame_done  out  one-clk pulse at the end of every frame
//
// Handshake: there is no valid/ready pair. frame_done is a single-cycle strobe
// that rises in the same cycle that joy1/joy2 show the committed frame. A
// consumer that wants to see every frame samples joy1/joy2 while frame_done=1.
// -----------------------------------------------------------------------------
module joy_serial_scanner #(
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned GAP_PERIODS = 0,
  parameter int unsigned FILTER      = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        joy_clk,
  output logic        joy_load,
  input  logic        joy_data,
  output logic [11:0] joy1,
  output logic [11:0] joy2,
  output logic        frame_done
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP_PERIODS > 0) ? (GAP_PERIODS - 1) : 0);
  localparam logic [4:0] LAST_BIT = 5'd23;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SHIFT  = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             sync1_q, sync2_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             joy_clk_q, joy_clk_d;
  logic             joy_load_q, joy_load_d;
  logic [2:0]       state_q, state_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             go_on_q, go_on_d;
  logic [23:0]      raw_q, raw_d;
  logic [23:0]      prev_q, prev_d;
  logic [11:0]      joy1_q, joy1_d;
  logic [11:0]      joy2_q, joy2_d;
  logic             frame_done_q, frame_done_d;

  logic             div_run;
  logic             div_wrap;
  logic             clk_rise;
  logic             park;
  logic             commit_ok;
  logic [11:0]      map_j1, map_j2;

  // ---------------------------------------------------------------------------
  // joy_data synchroniser. Two flops of delay is far shorter than a joy_clk
  // half-period, so the value seen at a rise is the bit that was stable across
  // the preceding high phase.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= joy_data;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    div_run  = (state_q != ST_IDLE) || enable;
    div_wrap = div_run && (div_cnt_q == DIV_LAST);
    clk_rise = div_wrap && !joy_clk_q;
  end

  // ---------------------------------------------------------------------------
  // FSM: advances only on joy_clk rises, except COMMIT which lasts one clk.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    go_on_d   = go_on_q;
    raw_d     = raw_q;

    case (state_q)
      ST_IDLE: begin
        // A rise can only happen here while enable=1 keeps the divider running.
        if (clk_rise) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        if (clk_rise) state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (clk_rise) begin
          state_d   = ST_SHIFT;
          bit_idx_d = 5'd0;
        end
      end

      ST_SHIFT: begin
        if (clk_rise) begin
          raw_d[bit_idx_q] = sync2_q;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_COMMIT;
            // Latch the continue decision here so joy_load can already drop
            // on this rise when the next LOAD follows COMMIT directly.
            go_on_d = enable;
          end else begin
            bit_idx_d = bit_idx_q + 5'd1;
          end
        end
      end

      ST_COMMIT: begin
        if (GAP_PERIODS > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = 4'd0;
        end else begin
          state_d = go_on_q ? ST_LOAD : ST_IDLE;
        end
      end

      ST_GAP: begin
        if (clk_rise) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = enable ? ST_LOAD : ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Divider and serial clock. Entering IDLE parks joy_clk low and restarts the
  // count, so a later enable gives its first rise a full CLK_DIV cycles later.
  // ---------------------------------------------------------------------------
  always_comb begin
    park = (state_d == ST_IDLE) && (state_q != ST_IDLE);

    if (!div_run || park) begin
      div_cnt_d = '0;
      joy_clk_d = 1'b0;
    end else if (div_wrap) begin
      div_cnt_d = '0;
      joy_clk_d = ~joy_clk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
      joy_clk_d = joy_clk_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Load strobe: low for exactly one joy_clk period (rise to rise). When COMMIT
  // leads straight into LOAD, the period starts at the final shift rise and
  // covers the one-clk COMMIT cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    joy_load_d = 1'b1;
    if (state_d == ST_LOAD) begin
      joy_load_d = 1'b0;
    end else if ((state_d == ST_COMMIT) && (GAP_PERIODS == 0) && go_on_d) begin
      joy_load_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Raw frame to joystick bit map
  // ---------------------------------------------------------------------------
  always_comb begin
    map_j1[8]  = raw_q[0];
    map_j1[6]  = raw_q[1];
    map_j1[5]  = raw_q[2];
    map_j1[4]  = raw_q[3];
    map_j1[3]  = raw_q[4];
    map_j1[2]  = raw_q[5];
    map_j1[1]  = raw_q[6];
    map_j1[0]  = raw_q[7];
    map_j1[10] = raw_q[20];
    map_j1[11] = raw_q[21];
    map_j1[9]  = raw_q[22];
    map_j1[7]  = raw_q[23];

    map_j2[8]  = raw_q[8];
    map_j2[6]  = raw_q[9];
    map_j2[5]  = raw_q[10];
    map_j2[4]  = raw_q[11];
    map_j2[3]  = raw_q[12];
    map_j2[2]  = raw_q[13];
    map_j2[1]  = raw_q[14];
    map_j2[0]  = raw_q[15];
    map_j2[10] = raw_q[16];
    map_j2[11] = raw_q[17];
    map_j2[9]  = raw_q[18];
    map_j2[7]  = raw_q[19];
  end

  // ---------------------------------------------------------------------------
  // Commit. Both words load in the same cycle. With the filter enabled a frame
  // is accepted only when it repeats the previous raw frame; the comparison
  // word always tracks the latest frame, accepted or not.
  // ---------------------------------------------------------------------------
  always_comb begin
    joy1_d       = joy1_q;
    joy2_d       = joy2_q;
    prev_d       = prev_q;
    commit_ok    = (FILTER == 0) || (raw_q == prev_q);
    frame_done_d = (state_q == ST_COMMIT);

    if (state_q == ST_COMMIT) begin
      prev_d = raw_q;
      if (commit_ok) begin
        joy1_d = map_j1;
        joy2_d = map_j2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q    <= '0;
      joy_clk_q    <= 1'b0;
      joy_load_q   <= 1'b1;
      state_q      <= ST_IDLE;
      bit_idx_q    <= 5'd0;
      gap_cnt_q    <= 4'd0;
      go_on_q      <= 1'b0;
      raw_q        <= 24'hFFFFFF;
      prev_q       <= 24'hFFFFFF;
      joy1_q       <= 12'hFFF;
      joy2_q       <= 12'hFFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      go_on_q      <= go_on_d;
      raw_q        <= raw_d;
      prev_q       <= prev_d;
      joy1_q       <= joy1_d;
      joy2_q       <= joy2_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign joy_clk    = joy_clk_q;
  assign joy_load   = joy_load_q;
  assign joy1       = joy1_q;
  assign joy2       = joy2_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_joy_serial_scanner.sv
// -----------------------------------------------------------------------------
// tb_joy_serial_scanner
//
// Two scanners share clock and reset:
//   index 0 (a): FILTER=0, GAP_PERIODS=0
//   index 1 (b): FILTER=1, GAP_PERIODS=4
// Each has a shift-register model that snapshots its 24-bit frame while
// joy_load is low and presents raw bit k during the joy_clk period before the
// rise that samples it. Core clock period is 10 time units.
// -----------------------------------------------------------------------------
module tb_joy_serial_scanner;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]  enable;
  logic [1:0]  joy_data;
  wire  [1:0]  joy_clk;
  wire  [1:0]  joy_load;
  wire  [1:0]  frame_done;
  wire  [11:0] joy1_a, joy2_a, joy1_b, joy2_b;

  joy_serial_scanner #(.CLK_DIV(16), .GAP_PERIODS(0), .FILTER(0)) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable[0]),
    .joy_clk    (joy_clk[0]),
    .joy_load   (joy_load[0]),
    .joy_data   (joy_data[0]),
    .joy1       (joy1_a),
    .joy2       (joy2_a),
    .frame_done (frame_done[0])
  );

  joy_serial_scanner #(.CLK_DIV(16), .GAP_PERIODS(4), .FILTER(1)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable[1]),
    .joy_clk    (joy_clk[1]),
    .joy_load   (joy_load[1]),
    .joy_data   (joy_data[1]),
    .joy1       (joy1_b),
    .joy2       (joy2_b),
    .frame_done (frame_done[1])
  );

  // ---------------------------------------------------------------------------
  // External shift register model
  // ---------------------------------------------------------------------------
  logic [23:0] frame [2];
  logic [23:0] snap  [2];
  int          rise_cnt [2];
  logic        clk_prev [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (joy_load[i] === 1'b0) begin
        snap[i]     = frame[i];
        rise_cnt[i] = 0;
        joy_data[i] = frame[i][0];
      end else begin
        if (joy_clk[i] === 1'b1 && clk_prev[i] === 1'b0) rise_cnt[i] = rise_cnt[i] + 1;
        if (rise_cnt[i] < 2)
          joy_data[i] = snap[i][0];
        else if (rise_cnt[i] - 2 < 24)
          joy_data[i] = snap[i][rise_cnt[i] - 2];
        else
          joy_data[i] = 1'b1;
      end
      clk_prev[i] = joy_clk[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the next frame_done of scanner idx; reports the number of
  // negedges taken and how many of them saw joy_load low.
  task automatic wait_fd(input int idx, input int budget, input string tag,
                         output int cycles, output int lows);
    logic got;
    got    = 1'b0;
    cycles = 0;
    lows   = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (joy_load[idx] === 1'b0) lows++;
      if (frame_done[idx] === 1'b1) got = 1'b1;
    end
    check(tag, 32'(got), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    int lows;
    int pulses;

    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    enable   = 2'b00;
    frame[0] = 24'hFFFFFF;
    frame[1] = 24'hFFFFFF;

    // Reset values
    repeat (4) @(negedge clk);
    check("rst_joy1_a",  32'(joy1_a),        32'hFFF);
    check("rst_joy2_a",  32'(joy2_a),        32'hFFF);
    check("rst_load_a",  32'(joy_load[0]),   32'd1);
    check("rst_clk_a",   32'(joy_clk[0]),    32'd0);
    check("rst_fd_a",    32'(frame_done[0]), 32'd0);
    check("rst_joy2_b",  32'(joy2_b),        32'hFFF);
    check("rst_load_b",  32'(joy_load[1]),   32'd1);

    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_clk_a",  32'(joy_clk[0]),  32'd0);
    check("idle_load_a", 32'(joy_load[0]), 32'd1);

    // Scanner a: raw[7]=0, raw[21]=0 -> joy1[0], joy1[11] low
    frame[0]  = 24'hDFFF7F;
    enable[0] = 1'b1;
    wait_fd(0, 2000, "a_fd1_seen", cyc, lows);
    check("a_fd1_latency", 32'(cyc), 32'd849);
    check("a_fd1_joy1", 32'(joy1_a), 32'h7FE);
    check("a_fd1_joy2", 32'(joy2_a), 32'hFFF);

    wait_fd(0, 2000, "a_fd2_seen", cyc, lows);
    check("a_fd_spacing", 32'(cyc),  32'd832);
    check("a_load_low",   32'(lows), 32'd32);
    check("a_fd2_joy1",   32'(joy1_a), 32'h7FE);

    // Scanner b: filter needs two matching frames
    enable[1] = 1'b1;
    wait_fd(1, 2000, "b_fd1_seen", cyc, lows);
    check("b_fd1_latency", 32'(cyc), 32'd849);
    check("b_fd1_joy2", 32'(joy2_b), 32'hFFF);

    frame[1] = 24'hFFFEFF;
    wait_fd(1, 2000, "b_fd2_seen", cyc, lows);
    check("b_fd_spacing", 32'(cyc),  32'd960);
    check("b_load_low",   32'(lows), 32'd32);
    check("b_single_joy2", 32'(joy2_b), 32'hFFF);

    frame[1] = 24'hFFFFFF;
    wait_fd(1, 2000, "b_fd3_seen", cyc, lows);
    check("b_back_joy2", 32'(joy2_b), 32'hFFF);

    frame[1] = 24'hFFFEFF;
    wait_fd(1, 2000, "b_fd4_seen", cyc, lows);
    check("b_first_of_pair_joy2", 32'(joy2_b), 32'hFFF);

    wait_fd(1, 2000, "b_fd5_seen", cyc, lows);
    check("b_pair_joy2", 32'(joy2_b), 32'hEFF);
    check("b_pair_joy1", 32'(joy1_b), 32'hFFF);

    // Scanner a: drop enable mid-shift (bit index 10)
    wait_fd(0, 900, "a_align_seen", cyc, lows);
    frame[0] = 24'hFEFFFE;
    repeat (390) @(negedge clk);
    enable[0] = 1'b0;
    wait_fd(0, 900, "a_last_seen", cyc, lows);
    check("a_last_latency", 32'(cyc), 32'd442);
    check("a_last_joy1", 32'(joy1_a), 32'hEFF);
    check("a_last_joy2", 32'(joy2_a), 32'hBFF);
    @(negedge clk);
    check("a_fd_pulse_width", 32'(frame_done[0]), 32'd0);
    repeat (2) @(negedge clk);
    check("a_stop_load", 32'(joy_load[0]), 32'd1);
    check("a_stop_clk",  32'(joy_clk[0]),  32'd0);
    pulses = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (frame_done[0] === 1'b1) pulses++;
    end
    check("a_no_more_fd", 32'(pulses), 32'd0);
    check("a_parked_clk", 32'(joy_clk[0]), 32'd0);

    // Scanner b: reset pulse mid-shift
    wait_fd(1, 1200, "b_align_seen", cyc, lows);
    repeat (400) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("b_rst_joy1", 32'(joy1_b),        32'hFFF);
    check("b_rst_joy2", 32'(joy2_b),        32'hFFF);
    check("b_rst_load", 32'(joy_load[1]),   32'd1);
    check("b_rst_clk",  32'(joy_clk[1]),    32'd0);
    check("b_rst_fd",   32'(frame_done[1]), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    cyc = 0;
    while (joy_load[1] !== 1'b0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("b_first_load", 32'(cyc), 32'd16);

    wait_fd(1, 2000, "b_post_fd1_seen", cyc, lows);
    check("b_post_fd1_latency", 32'(cyc), 32'd833);
    check("b_post_fd1_joy2", 32'(joy2_b), 32'hFFF);
    wait_fd(1, 2000, "b_post_fd2_seen", cyc, lows);
    check("b_post_spacing", 32'(cyc), 32'd960);
    check("b_post_fd2_joy2", 32'(joy2_b), 32'hEFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
